// File: rtl/parity_stream_decoder.sv
// Parity-checking word decoder with valid/ready on both sides and a 2-entry output buffer.
// Counts accepted words that fail the parity check in a saturating counter.
module parity_stream_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_ODD = 1'b0,
  parameter bit          DROP_ERR   = 1'b0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  // Each entry is {err, data}; slot0 always holds the oldest word.
  state_e                state_q, state_d;
  logic [DATA_WIDTH:0]   slot0_q, slot0_d;
  logic [DATA_WIDTH:0]   slot1_q, slot1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  word_err;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH:0]   new_entry;

  assign word_err  = (^in_data) ^ PARITY_ODD;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !(DROP_ERR && word_err);
  assign pop       = out_valid && out_ready;
  // With dropping enabled only clean words are stored, so the stored flag is always 0.
  assign new_entry = {word_err && !DROP_ERR, in_data[DATA_WIDTH-1:0]};

  // Ready comes from registered state only; held low while reset is asserted.
  assign in_ready  = arst_n && (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign out_byte  = slot0_q[DATA_WIDTH-1:0];
  assign out_err   = slot0_q[DATA_WIDTH];
  assign err_cnt   = cnt_q;

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          slot0_d = new_entry;
          state_d = StOne;
        end
      end
      StOne: begin
        if (push && !pop) begin
          slot1_d = new_entry;
          state_d = StFull;
        end else if (!push && pop) begin
          state_d = StEmpty;
        end else if (push && pop) begin
          slot0_d = new_entry;
        end
      end
      StFull: begin
        if (pop) begin
          slot0_d = slot1_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && word_err && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StEmpty;
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_stream_decoder.sv
// Bench for parity_stream_decoder: four instances (default, odd, drop, 4-bit counter)
// checked every cycle against a queue-based reference model.
module tb_parity_stream_decoder;

  localparam int ODD  [4] = '{0, 1, 0, 0};
  localparam int DROP [4] = '{0, 0, 1, 0};
  localparam int CMAX [4] = '{65535, 65535, 65535, 15};

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [8:0]  in_data   [4];
  logic        in_valid  [4];
  logic        in_ready  [4];
  logic [7:0]  out_byte  [4];
  logic        out_err   [4];
  logic        out_valid [4];
  logic        out_ready [4];
  logic        cnt_clr   [4];
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;
  logic [15:0] err_cnt   [4];

  assign err_cnt[0] = cnt0;
  assign err_cnt[1] = cnt1;
  assign err_cnt[2] = cnt2;
  assign err_cnt[3] = {12'b0, cnt3};

  always #5 clk = ~clk;

  parity_stream_decoder #(.DATA_WIDTH(8), .PARITY_ODD(1'b0), .DROP_ERR(1'b0), .CNT_WIDTH(16))
  dut_even (.clk(clk), .arst_n(arst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_byte(out_byte[0]), .out_err(out_err[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .cnt_clr(cnt_clr[0]), .err_cnt(cnt0));

  parity_stream_decoder #(.DATA_WIDTH(8), .PARITY_ODD(1'b1), .DROP_ERR(1'b0), .CNT_WIDTH(16))
  dut_odd (.clk(clk), .arst_n(arst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_byte(out_byte[1]), .out_err(out_err[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .cnt_clr(cnt_clr[1]), .err_cnt(cnt1));

  parity_stream_decoder #(.DATA_WIDTH(8), .PARITY_ODD(1'b0), .DROP_ERR(1'b1), .CNT_WIDTH(16))
  dut_drop (.clk(clk), .arst_n(arst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_byte(out_byte[2]), .out_err(out_err[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .cnt_clr(cnt_clr[2]), .err_cnt(cnt2));

  parity_stream_decoder #(.DATA_WIDTH(8), .PARITY_ODD(1'b0), .DROP_ERR(1'b0), .CNT_WIDTH(4))
  dut_sat (.clk(clk), .arst_n(arst_n), .in_data(in_data[3]), .in_valid(in_valid[3]),
    .in_ready(in_ready[3]), .out_byte(out_byte[3]), .out_err(out_err[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .cnt_clr(cnt_clr[3]), .err_cnt(cnt3));

  int         checks = 0;
  int         failures = 0;
  logic [8:0] mq   [4][$];  // model buffer, entries {err, data}
  logic [8:0] dlog [4][$];  // words the DUT actually delivered, {out_err, out_byte}
  int         mcnt [4];
  int         dacc [4];
  bit         last_acc [4];

  function automatic bit parity_bad(input int k, input logic [8:0] w);
    return ((^w) ^ (ODD[k] != 0)) == 1'b1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
  endtask

  // Compare all four instances against the model at the negedge, then advance the model
  // by the handshakes that the next rising edge will perform.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      bit exp_rdy;
      bit exp_vld;
      bit acc;
      bit werr;
      exp_rdy = (mq[k].size() < 2);
      exp_vld = (mq[k].size() != 0);
      checks++;
      if (in_ready[k] !== exp_rdy) begin
        failures++;
        $display("FAIL in_ready k=%0d got=%b want=%b t=%0t", k, in_ready[k], exp_rdy, $time);
      end
      checks++;
      if (out_valid[k] !== exp_vld) begin
        failures++;
        $display("FAIL out_valid k=%0d got=%b want=%b t=%0t", k, out_valid[k], exp_vld, $time);
      end
      if (exp_vld) begin
        checks++;
        if ({out_err[k], out_byte[k]} !== mq[k][0]) begin
          failures++;
          $display("FAIL out_word k=%0d got=%h want=%h t=%0t", k, {out_err[k], out_byte[k]},
                   mq[k][0], $time);
        end
      end
      checks++;
      if (err_cnt[k] !== 16'(mcnt[k])) begin
        failures++;
        $display("FAIL err_cnt k=%0d got=%0d want=%0d t=%0t", k, err_cnt[k], mcnt[k], $time);
      end
      if (in_valid[k] && in_ready[k]) dacc[k]++;
      if (out_valid[k] && out_ready[k]) dlog[k].push_back({out_err[k], out_byte[k]});
      acc  = in_valid[k] && exp_rdy;
      werr = parity_bad(k, in_data[k]);
      last_acc[k] = acc;
      if (out_ready[k] && exp_vld) void'(mq[k].pop_front());
      if (cnt_clr[k]) mcnt[k] = 0;
      else if (acc && werr && mcnt[k] < CMAX[k]) mcnt[k]++;
      if (acc && !(DROP[k] != 0 && werr)) mq[k].push_back({werr && DROP[k] == 0, in_data[k][7:0]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [8:0] w);
    bit done;
    done = 1'b0;
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      done = last_acc[k];
    end
    in_valid[k] = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL send_timeout k=%0d word=%h got=not_accepted want=accepted", k, w);
    end
  endtask

  task automatic check_log(input string name, input int k, input int idx, input logic [8:0] want);
    logic [8:0] got;
    got = (idx < dlog[k].size()) ? dlog[k][idx] : 9'bx;
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s k=%0d idx=%0d got=%h want=%h", name, k, idx, got, want);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b1; in_data[k] = 9'h0A5; out_ready[k] = 1'b1; cnt_clr[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 4; k++) begin
      check_val("reset_out_valid", int'(out_valid[k]), 0);
      check_val("reset_err_cnt", int'(err_cnt[k]), 0);
      check_val("reset_in_ready", int'(in_ready[k]), 0);
    end
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0;
    end
    arst_n = 1'b1;
    model_clear();
    repeat (3) step();
  endtask

  task automatic test_even();
    dlog[0].delete();
    out_ready[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 9'h0A5; step();
    in_data[0] = 9'h1A5; step();
    in_valid[0] = 1'b0;
    repeat (3) step();
    check_val("even_count", dlog[0].size(), 2);
    check_log("even_first", 0, 0, {1'b0, 8'hA5});
    check_log("even_second", 0, 1, {1'b1, 8'hA5});
    check_val("even_err_cnt", int'(err_cnt[0]), 1);
  endtask

  task automatic test_backpressure();
    int acc_before;
    dlog[0].delete();
    acc_before = dacc[0];
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 9'h000; step();
    in_data[0] = 9'h003; step();
    in_data[0] = 9'h005;
    repeat (3) step();
    check_val("bp_in_ready_low", int'(in_ready[0]), 0);
    check_val("bp_accepts", dacc[0] - acc_before, 2);
    check_val("bp_head_stable", int'(out_byte[0]), 0);
    out_ready[0] = 1'b1;
    send(0, 9'h005);
    repeat (4) step();
    check_val("bp_count", dlog[0].size(), 3);
    check_log("bp_w0", 0, 0, 9'h000);
    check_log("bp_w1", 0, 1, 9'h003);
    check_log("bp_w2", 0, 2, 9'h005);
  endtask

  task automatic test_odd();
    dlog[1].delete();
    out_ready[1] = 1'b1;
    send(1, 9'h1A5);
    send(1, 9'h0A5);
    repeat (3) step();
    check_log("odd_pass", 1, 0, {1'b0, 8'hA5});
    check_log("odd_fail", 1, 1, {1'b1, 8'hA5});
  endtask

  task automatic test_drop();
    int acc_before;
    dlog[2].delete();
    acc_before = dacc[2];
    out_ready[2] = 1'b1;
    send(2, 9'h0A5);
    send(2, 9'h1A5);
    send(2, 9'h03C);
    repeat (3) step();
    check_val("drop_count", dlog[2].size(), 2);
    check_log("drop_first", 2, 0, {1'b0, 8'hA5});
    check_log("drop_second", 2, 1, {1'b0, 8'h3C});
    check_val("drop_err_cnt", int'(err_cnt[2]), 1);
    check_val("drop_accepts", dacc[2] - acc_before, 3);
  endtask

  task automatic test_saturate();
    out_ready[3] = 1'b1;
    for (int i = 0; i < 20; i++) send(3, 9'h001 << (i % 9));
    repeat (2) step();
    check_val("sat_err_cnt", int'(err_cnt[3]), 15);
    cnt_clr[3] = 1'b1;
    send(3, 9'h001);
    cnt_clr[3] = 1'b0;
    step();
    check_val("clr_priority", int'(err_cnt[3]), 0);
    out_ready[3] = 1'b0;
    send(3, 9'h011);
    send(3, 9'h022);
    step();
    check_val("full_in_ready", int'(in_ready[3]), 0);
    #2;
    arst_n = 1'b0;
    #1;
    check_val("midreset_out_valid", int'(out_valid[3]), 0);
    check_val("midreset_in_ready", int'(in_ready[3]), 0);
    @(posedge clk);
    #2;
    arst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    repeat (2) step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = 9'($urandom);
        out_ready[k] = ($urandom_range(0, 2) != 0);
        cnt_clr[k]   = ($urandom_range(0, 40) == 0);
      end
      step();
    end
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; cnt_clr[k] = 1'b0;
    end
    repeat (4) step();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0; cnt_clr[k] = 1'b0;
      dacc[k] = 0; last_acc[k] = 1'b0; mcnt[k] = 0;
    end
    test_reset();
    test_even();
    test_backpressure();
    test_odd();
    test_drop();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
